mux_scan_ctrl: RTL and testbench
================================

// Module: mux_scan_ctrl
// PURPOSE
//   Sequencer for the 16:1 gate-level mux (mux_16x1). Drives the four select lines to
//   visit each enabled input channel in ascending order. Waits DWELL cycles per channel
//   for the select path to settle, samples the mux output, and assembles a 16-bit frame.
//   Delivers each frame over a valid/ready handshake, either single-shot or continuously.
// PARAMETERS
//   DWELL    2   settle cycles after each select change before sampling; legal range 1..15
//   DWELL_W  4   width of the internal dwell counter; must hold DWELL
// PORTS
//   clk          in   1   single clock; all state changes on rising edge
//   rst_n        in   1   reset, synchronous, active-low
//   start        in   1   request one scan; honoured only in IDLE
//   cont         in   1   continuous mode; checked at each frame handshake
//   mask         in   16  channel enable, bit i = channel i; latched at scan start
//   mux_y        in   1   output of mux_16x1 (y)
//   sel          out  4   select bus to mux_16x1: sel[0]=s0 .. sel[3]=s3
//   busy         out  1   high in any state other than IDLE
//   frame        out  16  bit i = sampled value of channel i; masked channels read 0
//   frame_valid  out  1   frame holds a complete scan
//   frame_ready  in   1   consumer accepts frame when frame_valid & frame_ready
// BEHAVIOUR
//   Reset (rst_n=0 at an edge): state=IDLE; sel=0; busy=0; frame=0; frame_valid=0;
//     dwell counter=0; capture buffer=0. Applies mid-scan: partial frame discarded.
//   FSM states: IDLE, SETTLE, SAMPLE, DONE.
//   IDLE: start=1 & mask!=0 -> latch mask. sel=lowest set bit. Clear buffer.
//     Next state SETTLE. start with mask==0 is ignored; stay IDLE.
//   SETTLE: count DWELL cycles with sel stable -> SAMPLE.
//   SAMPLE (1 cycle): buf[sel] <= mux_y.
//     - If a higher enabled channel exists: sel <= next enabled channel; -> SETTLE.
//     - Otherwise: frame <= buf incl. this sample; frame_valid <= 1; -> DONE.
//   Per enabled channel: exactly DWELL+1 cycles. Disabled channels are skipped at zero cost.
//   Latency: start seen at edge k, N enabled channels ->
//     frame_valid first high after edge k+N*(DWELL+1).
//   DONE: frame and frame_valid held stable until handshake (back-pressure; no overwrite).
//     On handshake: frame_valid <= 0.
//       - cont=1 & current mask!=0: relatch mask and start a new scan as in IDLE.
//       - Otherwise: -> IDLE.
//     frame keeps its value until the next frame is loaded.
//   start: ignored while busy. mask changes mid-scan: no effect until the next latch.
//   sel: changes only on IDLE->SETTLE, SAMPLE->SETTLE, or DONE->SETTLE transitions.
//     Never changes during SETTLE or SAMPLE. Holds its last value in DONE and IDLE.
//   Simultaneous start and handshake in DONE: start is ignored; cont alone decides.
// TESTING
//   1 mask=FFFF, DWELL=2, mux modelled from di=A5C3, start pulse
//       -> sel steps 0..F, 3 cycles each; frame=A5C3 at edge k+48; busy high throughout.
//   2 mask=0101, di=FFFF
//       -> only sel=0 and sel=8 visited; frame=0101 after 6 cycles.
//   3 start with mask=0000
//       -> stays IDLE, busy=0, frame_valid=0.
//   4 frame_ready=0 for 20 cycles after frame_valid
//       -> frame/frame_valid stable; sel unchanged; accepted on ready=1, then IDLE.
//   5 cont=1, mask=0003, di toggled between frames
//       -> back-to-back frames reflect new di; next scan starts the cycle after handshake.
//   6 rst_n=0 for one edge during SETTLE of ch5
//       -> all outputs 0, state IDLE; a fresh start then yields a full correct frame.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - select sequencer for mux_16x1: visits enabled channels, samples y, emits a 16-bit frame
module mux_scan_ctrl #(
  parameter int DWELL   = 2,
  parameter int DWELL_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cont,
  input  logic [15:0] mask,
  input  logic        mux_y,
  output logic [3:0]  sel,
  output logic        busy,
  output logic [15:0] frame,
  output logic        frame_valid,
  input  logic        frame_ready
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

  state_t             state;
  logic [15:0]        mask_q;
  logic [15:0]        cap;
  logic [DWELL_W-1:0] cnt;

  logic [15:0] above;
  logic        has_next;
  logic [3:0]  next_sel;
  logic [15:0] cap_now;

  function automatic logic [3:0] lowest(input logic [15:0] m);
    lowest = 4'd0;
    for (int i = 15; i >= 0; i--)
      if (m[i]) lowest = 4'(i);
  endfunction

  // Channels strictly above the current select; lowest of them is visited next.
  always_comb begin
    above    = mask_q & (16'hFFFE << sel);
    has_next = |above;
    next_sel = lowest(above);
    cap_now  = cap | ({15'b0, mux_y} << sel);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      sel         <= 4'd0;
      busy        <= 1'b0;
      frame       <= 16'd0;
      frame_valid <= 1'b0;
      cnt         <= '0;
      cap         <= 16'd0;
      mask_q      <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start && mask != 16'd0) begin
            mask_q <= mask;
            sel    <= lowest(mask);
            cap    <= 16'd0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == DWELL_LAST) begin
            cnt   <= '0;
            state <= SAMPLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SAMPLE: begin
          cap[sel] <= mux_y;
          if (has_next) begin
            sel   <= next_sel;
            state <= SETTLE;
          end else begin
            frame       <= cap_now;
            frame_valid <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          // Frame is held until accepted; start is ignored here, cont alone decides.
          if (frame_ready) begin
            frame_valid <= 1'b0;
            if (cont && mask != 16'd0) begin
              mask_q <= mask;
              sel    <= lowest(mask);
              cap    <= 16'd0;
              cnt    <= '0;
              state  <= SETTLE;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - scoreboard bench for mux_scan_ctrl with a behavioural mux and frame model
module tb_mux_scan_ctrl;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic [15:0] mask = 16'd0;
  logic        mux_y;
  logic [3:0]  sel;
  logic        busy;
  logic [15:0] frame;
  logic        frame_valid;
  logic        frame_ready = 1'b0;

  logic [15:0] di = 16'd0;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  int          ready_mode = 0;
  logic        ready_force = 1'b0;
  logic [15:0] last_frame = 16'd0;

  typedef struct {
    logic [15:0] frame;
    logic [15:0] mask;
  } exp_t;
  exp_t sb[$];

  mux_scan_ctrl #(.DWELL(D), .DWELL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .mask(mask),
    .mux_y(mux_y), .sel(sel), .busy(busy), .frame(frame),
    .frame_valid(frame_valid), .frame_ready(frame_ready)
  );

  assign mux_y = di[sel];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) frame_ready = ($urandom_range(0, 3) != 0);
      else frame_ready = ready_force;
    end
  end

  // Monitor: scan timing, channel visit counts, hold stability, frame contents.
  int          cnt_ch[16];
  int          scan_start = 0;
  bit          order_ok = 1'b1;
  bit          first_in_scan = 1'b1;
  logic [3:0]  last_sel = 4'd0;
  bit          prev_fv = 1'b0, prev_hs = 1'b0, prev_busy = 1'b0;
  logic [15:0] prev_frame = 16'd0;
  logic [3:0]  prev_sel = 4'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      foreach (cnt_ch[i]) cnt_ch[i] = 0;
      prev_fv = 1'b0; prev_hs = 1'b0; prev_busy = 1'b0;
      order_ok = 1'b1; first_in_scan = 1'b1;
    end else begin
      if (prev_fv && !prev_hs) begin
        vectors++;
        if (!(frame_valid && busy && frame == prev_frame && sel == prev_sel)) begin
          miscompares++;
          $display("FAIL hold: fv=%b busy=%b frame=%h sel=%0d, want fv=1 busy=1 frame=%h sel=%0d",
                   frame_valid, busy, frame, sel, prev_frame, prev_sel);
        end
      end
      if (busy && (!prev_busy || prev_hs)) begin
        scan_start = cyc;
        foreach (cnt_ch[i]) cnt_ch[i] = 0;
        order_ok = 1'b1;
        first_in_scan = 1'b1;
      end
      if (busy && !frame_valid) begin
        cnt_ch[sel]++;
        if (!first_in_scan && sel < last_sel) order_ok = 1'b0;
        last_sel = sel;
        first_in_scan = 1'b0;
      end
      if (frame_valid && !prev_fv) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL spurious_frame: frame=%h with no scan expected", frame);
        end else begin
          int want_cyc;
          bit visits_ok;
          want_cyc = scan_start + $countones(sb[0].mask) * (D + 1);
          visits_ok = order_ok;
          for (int i = 0; i < 16; i++)
            if (cnt_ch[i] != (sb[0].mask[i] ? D + 1 : 0)) visits_ok = 1'b0;
          if (cyc != want_cyc || !visits_ok) begin
            miscompares++;
            $display("FAIL latency/visits: valid at edge %0d want %0d, visits_ok=%b mask=%h",
                     cyc, want_cyc, visits_ok, sb[0].mask);
          end
        end
      end
      if (frame_valid && frame_ready && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        vectors++;
        if (frame !== e.frame) begin
          miscompares++;
          $display("FAIL frame: got %h want %h (mask %h)", frame, e.frame, e.mask);
        end
      end
      prev_hs    = frame_valid && frame_ready;
      prev_fv    = frame_valid;
      prev_busy  = busy;
      prev_frame = frame;
      prev_sel   = sel;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) timeout("wait_idle");
    tick();
  endtask

  task automatic wait_hs(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (frame_valid && frame_ready) done = 1'b1;
    end
    if (!done) timeout("wait_handshake");
    tick();
  endtask

  task automatic run_scan(input logic [15:0] m, input logic [15:0] d);
    mask = m;
    di = d;
    if (m != 16'd0) begin
      sb.push_back('{frame: d & m, mask: m});
      last_frame = d & m;
    end
    start = 1'b1;
    tick();
    start = (m != 16'd0);
    tick();
    start = 1'b0;
    mask = 16'($urandom);
    if (m == 16'd0) begin
      @(negedge clk);
      check("zero_mask_ignored", {busy, frame_valid, frame}, {2'b00, last_frame});
      tick();
    end else begin
      wait_idle(800);
    end
  endtask

  initial begin
    repeat (3) tick();
    check("reset_state", {sel, busy, frame, frame_valid}, 22'd0);
    rst_n = 1'b1;
    tick();

    run_scan(16'hFFFF, 16'hA5C3);
    run_scan(16'h0101, 16'hFFFF);
    run_scan(16'h0000, 16'hFFFF);

    // Back-pressure: consumer stalls for 20 cycles after the frame appears.
    ready_mode = 1; ready_force = 1'b0;
    mask = 16'h8421; di = 16'($urandom);
    sb.push_back('{frame: di & 16'h8421, mask: 16'h8421});
    last_frame = di & 16'h8421;
    start = 1'b1; tick(); start = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge clk);
        if (frame_valid) seen = 1'b1;
      end
      if (!seen) timeout("backpressure_valid");
    end
    repeat (20) @(negedge clk);
    tick();
    ready_force = 1'b1;
    wait_idle(50);
    check("after_accept", {busy, frame_valid, frame}, {2'b00, last_frame});

    // Continuous mode: new data per frame, restart right after each handshake.
    cont = 1'b1; mask = 16'h0003; di = 16'($urandom);
    sb.push_back('{frame: di & 16'h0003, mask: 16'h0003});
    start = 1'b1; tick(); start = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      wait_hs(100);
      di = 16'($urandom);
      sb.push_back('{frame: di & 16'h0003, mask: 16'h0003});
      last_frame = di & 16'h0003;
      if (j == 3) cont = 1'b0;
    end
    wait_idle(100);
    ready_mode = 0;

    // Reset while channel 5 is settling; partial frame is discarded.
    mask = 16'hFFFF; di = 16'($urandom);
    start = 1'b1; tick(); start = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        if (busy && sel == 4'd5) seen = 1'b1;
      end
      if (!seen) timeout("reach_ch5");
    end
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    check("mid_scan_reset", {sel, busy, frame, frame_valid}, 22'd0);
    last_frame = 16'd0;
    run_scan(16'hFFFF, 16'($urandom));

    for (int n = 0; n < 20; n++) begin
      logic [15:0] m;
      m = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
      run_scan(m, 16'($urandom));
    end

    repeat (5) tick();
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
